switch_scan_ctrl: RTL and testbench

//   Sequencer and bus front-end for the 64-bit DIP-switch bank. Synchronises the raw

---
 rtl/switch_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_switch_scan_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_scan_ctrl.sv
// switch_scan_ctrl: synchronises and debounces a 64-bit active-low DIP bank, publishes it as a
// four-word register file with a change interrupt. Define SWITCH_SNAPSHOT_EN for a tear-free high-word shadow.
module switch_scan_ctrl #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [63:0] dip_raw_i,
    input  logic        sel_i,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        irq_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [63:0]      sync1_q, sync2_q;
    logic [63:0]      stable_q, stable_d;
    logic [63:0]      cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             changed_q, changed_d;
    logic             primed_q, primed_d;
    logic             irqEn_q, irqEn_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
`ifdef SWITCH_SNAPSHOT_EN
    logic [31:0]      shadow_q, shadow_d;
`endif

    logic [63:0] syncWord;
    logic        rdStrobe;
    logic        wrStrobe;
    logic        commit;
    logic [30:0] unusedWdata;

    assign syncWord    = ~sync2_q;
    assign rdStrobe    = sel_i & ~we_i;
    assign wrStrobe    = sel_i & we_i;
    assign unusedWdata = wdata_i[31:1];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            changed_q <= 1'b0;
            primed_q  <= 1'b0;
            irqEn_q   <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
`ifdef SWITCH_SNAPSHOT_EN
            shadow_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= dip_raw_i;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
            primed_q  <= primed_d;
            irqEn_q   <= irqEn_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
`ifdef SWITCH_SNAPSHOT_EN
            shadow_q  <= shadow_d;
`endif
        end
    end

    // Any change of the synced word while settling restarts the window, even a bounce back
    // to the committed value; the window always runs out and commits whatever it holds.
    always_comb begin
        state_d   = state_q;
        stable_d  = stable_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        changed_d = changed_q;
        primed_d  = primed_q;
        irqEn_d   = irqEn_q;
        rdata_d   = rdata_q;
        rvalid_d  = rdStrobe;
        commit    = 1'b0;
`ifdef SWITCH_SNAPSHOT_EN
        shadow_d  = shadow_q;
`endif

        case (state_q)
            IDLE: begin
                if (syncWord != stable_q) begin
                    cand_d  = syncWord;
                    cnt_d   = RELOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (syncWord != cand_q) begin
                    cand_d = syncWord;
                    cnt_d  = RELOAD;
                end else if (cnt_q == '0) begin
                    stable_d = cand_q;
                    state_d  = IDLE;
                    commit   = 1'b1;
                    primed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The power-up commit is silent, and a commit beats a same-cycle clear.
        if (wrStrobe && addr_i == 2'd2 && wdata_i[0]) begin
            changed_d = 1'b0;
        end
        if (commit && primed_q) begin
            changed_d = 1'b1;
        end
        if (wrStrobe && addr_i == 2'd3) begin
            irqEn_d = wdata_i[0];
        end

        if (rdStrobe) begin
            case (addr_i)
                2'd0: rdata_d = stable_q[31:0];
`ifdef SWITCH_SNAPSHOT_EN
                2'd1: rdata_d = shadow_q;
`else
                2'd1: rdata_d = stable_q[63:32];
`endif
                2'd2: rdata_d = {29'b0, primed_q, (state_q == SETTLE), changed_q};
                default: rdata_d = {31'b0, irqEn_q};
            endcase
`ifdef SWITCH_SNAPSHOT_EN
            if (addr_i == 2'd0) begin
                shadow_d = stable_q[63:32];
            end
`endif
        end
    end

    always_comb begin
        irq_o    = changed_q & irqEn_q;
        rdata_o  = rdata_q;
        rvalid_o = rvalid_q;
    end

endmodule

// File: tb/tb_switch_scan_ctrl.sv
// tb_switch_scan_ctrl: directed table, hand-written corner sequences and randomized traffic
// for switch_scan_ctrl (DEBOUNCE_CYCLES=4), checked against a run-length reference model.
module tb_switch_scan_ctrl;

    localparam int DEB = 4;
    localparam int WIN = DEB + 1;
`ifdef SWITCH_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] dipRaw = 64'hFFFF_FFFF_FFFF_FF00;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    int checks = 0;
    int errors = 0;

    switch_scan_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .dip_raw_i(dipRaw),
        .sel_i    (sel),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .rdata_o  (rdata),
        .rvalid_o (rvalid),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    // Reference model: the committed word is the first synced value seen unchanged for
    // WIN consecutive clocks since the disagreement with the committed word was noticed.
    logic [63:0] pipe[$];
    logic [63:0] hist[$];
    logic [63:0] mdlStable;
    bit          mdlPending, mdlChanged, mdlPrimed, mdlIrqEn, mdlRvalid;
    logic [31:0] mdlRdata, mdlShadow;

    task automatic modelReset();
        pipe.delete();
        pipe.push_back(64'h0);
        pipe.push_back(64'h0);
        hist.delete();
        mdlStable = '0; mdlPending = 0; mdlChanged = 0; mdlPrimed = 0;
        mdlIrqEn = 0; mdlRvalid = 0; mdlRdata = '0; mdlShadow = '0;
    endtask

    task automatic modelStep();
        logic [63:0] sample;
        bit commit, setChanged, eq;
        sample = ~pipe[0];
        mdlRvalid = sel && !we;
        if (sel && !we) begin
            case (addr)
                2'd0: mdlRdata = mdlStable[31:0];
                2'd1: mdlRdata = SNAP ? mdlShadow : mdlStable[63:32];
                2'd2: mdlRdata = {29'b0, mdlPrimed, mdlPending, mdlChanged};
                default: mdlRdata = {31'b0, mdlIrqEn};
            endcase
            if (SNAP && addr == 2'd0) mdlShadow = mdlStable[63:32];
        end
        commit = 0;
        if (!mdlPending) begin
            if (sample != mdlStable) begin
                mdlPending = 1;
                hist.delete();
                hist.push_back(sample);
            end
        end else begin
            hist.push_back(sample);
            if (hist.size() > WIN) void'(hist.pop_front());
            eq = (hist.size() == WIN);
            foreach (hist[i]) if (hist[i] != sample) eq = 0;
            commit = eq;
        end
        setChanged = commit && mdlPrimed;
        if (commit) begin
            mdlStable = sample;
            mdlPending = 0;
            mdlPrimed = 1;
            hist.delete();
        end
        if (sel && we && addr == 2'd2 && wdata[0]) mdlChanged = 0;
        if (setChanged) mdlChanged = 1;
        if (sel && we && addr == 2'd3) mdlIrqEn = wdata[0];
        void'(pipe.pop_front());
        pipe.push_back(dipRaw);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // One clock: model and DUT see the same inputs, outputs compared half a cycle later.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput("rvalid", {31'b0, rvalid}, {31'b0, mdlRvalid});
        checkOutput("rdata", rdata, mdlRdata);
        checkOutput("irq", {31'b0, irq}, {31'b0, mdlChanged & mdlIrqEn});
        sel = 1'b0;
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic busRead(input logic [1:0] a);
        sel = 1'b1; we = 1'b0; addr = a;
        applyStimulus();
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        applyStimulus();
    endtask

    task automatic countToIrq(output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus();
            if (irq === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        vecs[0]  = '{1'b0, 2'd0, 32'h0,         32'h0000_00FF};
        vecs[1]  = '{1'b0, 2'd1, 32'h0,         32'h0000_0000};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,         32'h0000_0004};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,         32'h0000_0000};
        vecs[4]  = '{1'b1, 2'd0, 32'hDEAD_BEEF, 32'h0};
        vecs[5]  = '{1'b0, 2'd0, 32'h0,         32'h0000_00FF};
        vecs[6]  = '{1'b1, 2'd1, 32'h1234_5678, 32'h0};
        vecs[7]  = '{1'b0, 2'd1, 32'h0,         32'h0000_0000};
        vecs[8]  = '{1'b1, 2'd3, 32'hFFFF_FFFE, 32'h0};
        vecs[9]  = '{1'b0, 2'd3, 32'h0,         32'h0000_0000};
        vecs[10] = '{1'b1, 2'd3, 32'h0000_0001, 32'h0};
        vecs[11] = '{1'b0, 2'd3, 32'h0,         32'h0000_0001};
        vecs[12] = '{1'b1, 2'd2, 32'h0000_0001, 32'h0};
        vecs[13] = '{1'b0, 2'd2, 32'h0,         32'h0000_0004};

        #1 rst_n = 1'b0;
        #1;
        checkOutput("resetRdata", rdata, 32'h0);
        checkOutput("resetRvalid", {31'b0, rvalid}, 32'h0);
        checkOutput("resetIrq", {31'b0, irq}, 32'h0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Power-up commit after 7 clocks, silent.
        idle(7);
        for (int i = 0; i < 14; i++) begin
            sel = 1'b1; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
            applyStimulus();
            if (!vecs[i].we) begin
                checkOutput($sformatf("tblRvalid%0d", i), {31'b0, rvalid}, 32'h1);
                checkOutput($sformatf("tblRdata%0d", i), rdata, vecs[i].expRd);
            end
        end

        // Switch 7 on: irq rises 7 clocks after the raw change (5 after the synced change).
        dipRaw[63:56] = 8'h00;
        countToIrq(n);
        checkOutput("irqLatency", n, 32'd7);
        busRead(2'd1);
        checkOutput("highWord", rdata, 32'hFF00_0000);
        busRead(2'd2);
        checkOutput("statusChanged", rdata, 32'h0000_0005);

        // Bit 0 bouncing every 3 clocks never commits; the final equal value still commits.
        busWrite(2'd2, 32'h1);
        for (int i = 0; i < 10; i++) begin
            dipRaw[0] = ~dipRaw[0];
            if (i >= 1) begin
                busRead(2'd2);
                checkOutput("bounceSettle", rdata, 32'h0000_0006);
            end else begin
                applyStimulus();
            end
            idle(2);
        end
        checkOutput("bounceNoIrq", {31'b0, irq}, 32'h0);
        countToIrq(n);
        checkOutput("bounceCommit", n, 32'd4);
        busRead(2'd0);
        checkOutput("bounceValue", rdata, 32'h0000_00FF);

        // Clear in the commit cycle loses to the set.
        busWrite(2'd2, 32'h1);
        dipRaw[15:8] = 8'h00;
        idle(6);
        busWrite(2'd2, 32'h1);
        checkOutput("raceIrq", {31'b0, irq}, 32'h1);
        busRead(2'd2);
        checkOutput("raceStatus", rdata, 32'h0000_0005);
        busWrite(2'd2, 32'h1);
        checkOutput("clearIrq", {31'b0, irq}, 32'h0);
        busRead(2'd2);
        checkOutput("clearStatus", rdata, 32'h0000_0004);
        busRead(2'd0);
        checkOutput("lowWord", rdata, 32'h0000_FFFF);

        // Pair read across a high-word commit.
        busRead(2'd0);
        dipRaw[63:56] = 8'hFF;
        idle(8);
        busRead(2'd1);
        checkOutput("pairHigh", rdata, SNAP ? 32'hFF00_0000 : 32'h0000_0000);

        // Reset in the middle of a settle window.
        dipRaw[23:16] = 8'h00;
        idle(8);
        dipRaw[31:24] = 8'h00;
        idle(3);
        busRead(2'd0);
        checkOutput("preResetRdata", rdata, 32'h00FF_FFFF);
        checkOutput("preResetIrq", {31'b0, irq}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midResetRdata", rdata, 32'h0);
        checkOutput("midResetRvalid", {31'b0, rvalid}, 32'h0);
        checkOutput("midResetIrq", {31'b0, irq}, 32'h0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        busRead(2'd0);
        checkOutput("postResetStable", rdata, 32'h0);
        idle(8);
        busWrite(2'd3, 32'h1);

        // Randomized switch activity and bus traffic.
        for (int b = 0; b < 150; b++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 7) begin
                int k;
                k = $urandom_range(0, 7);
                dipRaw[k*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            end else if (r < 9) begin
                dipRaw = {$urandom, $urandom};
            end
            repeat ($urandom_range(1, 9)) begin
                int o;
                o = $urandom_range(0, 9);
                if (o < 4) busRead(2'($urandom_range(0, 3)));
                else if (o == 4) busWrite(2'd2, $urandom);
                else if (o == 5) busWrite(2'd3, $urandom);
                else if (o == 6) busWrite(2'($urandom_range(0, 1)), $urandom);
                else applyStimulus();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
